md_scheduler: RTL

Sequencing controller for the multiply/divide unit in the Execute stage. Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E, latches operands into a combinational arithmetic core, counts the fixed op latency, owns the HI/LO registers, and produces `start`, `busy` and the D-stage stall request. The pipeline hazard unit ORs `stall` into its freeze logic.

---
 rtl/md_scheduler_if.sv | 29 ++
 rtl/md_scheduler.sv | 107 ++++++++++
 2 files changed

// File: rtl/md_scheduler_if.sv
// Execute-stage multiply/divide bundle: instruction handshake, core datapath hookup and HI/LO results.
interface md_scheduler_if;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        d_is_md;
    logic [31:0] dp_hi;
    logic [31:0] dp_lo;
    logic [1:0]  dp_op;
    logic [31:0] dp_a;
    logic [31:0] dp_b;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport slave (
        input  e_valid, e_md_op, op_a, op_b, d_is_md, dp_hi, dp_lo,
        output dp_op, dp_a, dp_b, start, busy, stall, hi, lo, md_out
    );

    modport master (
        output e_valid, e_md_op, op_a, op_b, d_is_md, dp_hi, dp_lo,
        input  dp_op, dp_a, dp_b, start, busy, stall, hi, lo, md_out
    );
endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer: latches operands for the arithmetic core, times the fixed
// latency, owns HI/LO and raises the D-stage stall while an md op is pending or in flight.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    md_scheduler_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        is_arith;
    logic [1:0]  op_code;
    logic [3:0]  cnt_load;
    logic        done;
    logic        div_zero;
    logic        move_ok;

    always_comb begin
        is_arith = 1'b0;
        op_code  = 2'd0;
        cnt_load = MULT_LOAD;
        case (bus.e_md_op)
            4'd1: begin is_arith = 1'b1; op_code = 2'd0; cnt_load = MULT_LOAD; end
            4'd2: begin is_arith = 1'b1; op_code = 2'd1; cnt_load = MULT_LOAD; end
            4'd3: begin is_arith = 1'b1; op_code = 2'd2; cnt_load = DIV_LOAD;  end
            4'd4: begin is_arith = 1'b1; op_code = 2'd3; cnt_load = DIV_LOAD;  end
            default: ;
        endcase
    end

    assign done     = (state == RUN) && (cnt == 4'd1);
    assign div_zero = bus.dp_op[1] && (bus.dp_b == 32'd0);
    // Moves to HI/LO are only honoured when nothing is in flight; a completion always wins.
    assign move_ok  = (state == IDLE) && bus.e_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        bus.start  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.e_valid && is_arith) begin
                    bus.start  = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.busy  = (state == RUN);
    assign bus.stall = bus.d_is_md && (bus.start || bus.busy);

    always_comb begin
        bus.md_out = 32'd0;
        case (bus.e_md_op)
            4'd7:    bus.md_out = bus.hi;
            4'd8:    bus.md_out = bus.lo;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            bus.dp_op <= 2'd0;
            bus.dp_a  <= 32'd0;
            bus.dp_b  <= 32'd0;
            bus.hi    <= 32'd0;
            bus.lo    <= 32'd0;
        end else begin
            if (bus.start) begin
                cnt       <= cnt_load;
                bus.dp_op <= op_code;
                bus.dp_a  <= bus.op_a;
                bus.dp_b  <= bus.op_b;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end

            if (done) begin
                if (!div_zero) begin
                    bus.hi <= bus.dp_hi;
                    bus.lo <= bus.dp_lo;
                end
            end else if (move_ok) begin
                if (bus.e_md_op == 4'd5) bus.hi <= bus.op_a;
                if (bus.e_md_op == 4'd6) bus.lo <= bus.op_a;
            end
        end
    end
endmodule
